jtag_tap_controller: RTL and testbench
======================================

// Module: jtag_tap_controller
// PURPOSE
//  IEEE 1149.1-style TAP: 16-state FSM, 3-bit instruction register, bypass register and TDO mux.
//  Sits upstream of the SDRAM-controller boundary-scan register (BSR).
//  Drives BSR capture/shift/update enables and the pin-vs-core mode select; takes the BSR serial-out back.
//  Single TCK domain: all BSR control is clock-enables, no gated clocks.
// PARAMETERS
//  IR_size    3       instruction register width
//  IR_CAPTURE 3'b001  value loaded into IR shift stage in Capture-IR (LSB must be 1)
// PORTS
//  TCK          in   1        test clock; all flops on rising edge
//  reset        in   1        synchronous, active-high; forces Test-Logic-Reset
//  TMS          in   1        test mode select, sampled on TCK rise
//  TDI          in   1        test data in; also drives BSR serial-in directly
//  TDO          out  1        registered test data out
//  enableTDO    out  1        registered; 1 while TDO valid (after Shift-IR/Shift-DR edges)
//  BSR_scan_out in   1        serial-out of external BSR
//  captureDR    out  1        BSR capture enable (state==Capture-DR and BSR selected)
//  shiftDR      out  1        BSR shift enable (state==Shift-DR and BSR selected)
//  updateDR     out  1        BSR update enable (state==Update-DR and BSR selected)
//  test_mode    out  1        1 when active instruction is EXTEST or INTEST: BSR drives pins/core
//  select_BR    out  1        1 when active instruction selects bypass
//  instruction  out  IR_size  active instruction
//  tap_state    out  4        current FSM state code
//  reset_bar    out  1        0 while in Test-Logic-Reset
// BEHAVIOUR
//  States (code): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5,
//   SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
//  Transitions per 1149.1, on each TCK rise from TMS:
//   TLR: 1->TLR, 0->RTI. RTI: 1->SelDR, 0->RTI. SelDR: 1->SelIR, 0->CapDR.
//   SelIR: 1->TLR, 0->CapIR. Cap*: 1->Ex1*, 0->Sh*. Sh*: 1->Ex1*, 0->Sh*.
//   Ex1*: 1->Upd*, 0->Pau*. Pau*: 1->Ex2*, 0->Pau*. Ex2*: 1->Upd*, 0->Sh*. Upd*: 1->SelDR, 0->RTI.
//  Five consecutive TMS=1 reach TLR from any state.
//  Reset: reset=1 on a TCK rise sets the following, in that same cycle; reset has priority over TMS:
//   - state=TLR, instruction=BYPASS, IR shift stage=IR_CAPTURE, bypass reg=0;
//   - TDO=0, enableTDO=0.
//  Holding reset mid-shift aborts the shift; the instruction is not updated.
//  In TLR, instruction is forced to BYPASS every cycle.
//  Instruction encodings:
//   - EXTEST=000, SAMPLE_PRELOAD=001, INTEST=010, BYPASS=111;
//   - any other code decodes as BYPASS (select_BR=1, test_mode=0).
//  IR datapath:
//   - CapIR edge: shift stage<=IR_CAPTURE;
//   - ShIR edge: shift stage<={TDI, stage[IR_size-1:1]}, TDO<=stage[0];
//   - UpdIR edge: instruction<=shift stage.
//  Bypass: CapDR edge with bypass selected: byp<=0. ShDR edge: byp<=TDI, TDO<=byp.
//   TDI bit therefore appears on TDO after 2 shift edges.
//  BSR: captureDR/shiftDR/updateDR are combinational decodes of state and instruction.
//   On a ShDR edge with BSR selected: TDO<=BSR_scan_out.
//  enableTDO<=1 on any ShIR/ShDR edge; otherwise <=0. TDO holds its value when not shifting.
//  Latency: instruction changes on the UpdIR edge; test_mode/select_BR follow combinationally.
//   All outputs other than TDO and enableTDO are combinational from registered state.
// TESTING
//  1. From each of the 16 states, apply TMS=1 x5 -> tap_state=F, instruction=111, reset_bar=0.
//  2. TLR->RTI->SelDR->SelIR->CapIR, shift TDI=0,0,0 then Ex1IR->UpdIR.
//     Expected: TDO sequence 1,0,0 (captured 001); instruction=000; test_mode=1.
//  3. Load BYPASS, enter ShDR, shift TDI=1,0,1,1.
//     Expected: TDO=0 (captured bypass bit),1,0,1 on successive edges; captureDR/shiftDR stay 0.
//  4. Load SAMPLE_PRELOAD, pass CapDR, shift 268 cycles, Ex1DR->UpdDR.
//     Expected: captureDR high exactly 1 cycle, shiftDR 268, updateDR 1; TDO tracks BSR_scan_out.
//  5. Assert reset during ShIR after 1 bit loaded with code 010.
//     Expected: next edge state=F, instruction=111, enableTDO=0; instruction never becomes 010.
//  6. Load illegal code 101 -> select_BR=1, test_mode=0, bypass path behaves as in scenario 3.

Source files
------------

// File: rtl/jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// jtag_tap_controller
//   IEEE 1149.1-style Test Access Port: 16-state TAP FSM, IR_size-bit
//   instruction register, single-bit bypass register and registered TDO mux.
//   Sits in front of the SDRAM-controller boundary-scan register (BSR):
//   generates the BSR capture/shift/update enables and the pin-vs-core mode
//   select, and returns the BSR serial-out on TDO. Everything runs on TCK;
//   BSR control is delivered as clock enables, never as gated clocks.
//
// Ports
//   TCK           in   test clock, all flops on rising edge
//   reset         in   synchronous active-high, forces Test-Logic-Reset
//   TMS           in   test mode select
//   TDI           in   test data in (also the BSR serial-in)
//   TDO           out  registered test data out
//   enableTDO     out  registered, high after Shift-IR/Shift-DR edges
//   BSR_scan_out  in   serial-out of the external BSR
//   captureDR     out  BSR capture enable
//   shiftDR       out  BSR shift enable
//   updateDR      out  BSR update enable
//   test_mode     out  EXTEST/INTEST active: BSR drives pins/core
//   select_BR     out  bypass register selected
//   instruction   out  active instruction
//   tap_state     out  current TAP state code
//   reset_bar     out  low while in Test-Logic-Reset
// -----------------------------------------------------------------------------
module jtag_tap_controller #(
    parameter int                  IR_size    = 3,
    parameter logic [IR_size-1:0]  IR_CAPTURE = IR_size'(1)
) (
    input  logic               TCK,
    input  logic               reset,
    input  logic               TMS,
    input  logic               TDI,
    output logic               TDO,
    output logic               enableTDO,
    input  logic               BSR_scan_out,
    output logic               captureDR,
    output logic               shiftDR,
    output logic               updateDR,
    output logic               test_mode,
    output logic               select_BR,
    output logic [IR_size-1:0] instruction,
    output logic [3:0]         tap_state,
    output logic               reset_bar
);

    typedef enum logic [3:0] {
        ST_TLR    = 4'hF, ST_RTI    = 4'hC,
        ST_SEL_DR = 4'h7, ST_CAP_DR = 4'h6, ST_SH_DR  = 4'h2, ST_EX1_DR = 4'h1,
        ST_PAU_DR = 4'h3, ST_EX2_DR = 4'h0, ST_UPD_DR = 4'h5,
        ST_SEL_IR = 4'h4, ST_CAP_IR = 4'hE, ST_SH_IR  = 4'hA, ST_EX1_IR = 4'h9,
        ST_PAU_IR = 4'hB, ST_EX2_IR = 4'h8, ST_UPD_IR = 4'hD
    } tap_state_t;

    localparam logic [IR_size-1:0] EXTEST         = IR_size'(0);
    localparam logic [IR_size-1:0] SAMPLE_PRELOAD = IR_size'(1);
    localparam logic [IR_size-1:0] INTEST         = IR_size'(2);
    localparam logic [IR_size-1:0] BYPASS         = '1;

    tap_state_t         state, state_next;
    logic [IR_size-1:0] ir_shift;
    logic [IR_size-1:0] ir_active;
    logic               byp;
    logic               bsr_sel;

    // Next-state logic: standard 1149.1 TMS-driven transitions.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_TLR:    state_next = TMS ? ST_TLR    : ST_RTI;
            ST_RTI:    state_next = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_next = TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_next = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_next = TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_next = TMS ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: state_next = TMS ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: state_next = TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_next = TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: state_next = TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_next = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_next = TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_next = TMS ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: state_next = TMS ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: state_next = TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_next = TMS ? ST_SEL_DR : ST_RTI;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge TCK) begin
        if (reset) state <= ST_TLR;
        else       state <= state_next;
    end

    // Instruction register: capture/shift stage plus the active (update) stage.
    // The active instruction is forced to BYPASS on any edge that lands in or
    // stays in Test-Logic-Reset, so TLR always presents BYPASS even when it
    // was reached through Update-IR on the way.
    always_ff @(posedge TCK) begin
        if (reset) begin
            ir_shift  <= IR_CAPTURE;
            ir_active <= BYPASS;
        end else begin
            if (state == ST_CAP_IR)
                ir_shift <= IR_CAPTURE;
            else if (state == ST_SH_IR)
                ir_shift <= {TDI, ir_shift[IR_size-1:1]};

            if (state_next == ST_TLR)
                ir_active <= BYPASS;
            else if (state == ST_UPD_IR)
                ir_active <= ir_shift;
        end
    end

    // Instruction decode: unknown codes fall back to bypass.
    always_comb begin
        bsr_sel   = (ir_active == EXTEST) || (ir_active == SAMPLE_PRELOAD) ||
                    (ir_active == INTEST);
        test_mode = (ir_active == EXTEST) || (ir_active == INTEST);
        select_BR = !bsr_sel;
    end

    // Bypass register and the registered TDO mux. TDO holds between shifts.
    always_ff @(posedge TCK) begin
        if (reset) begin
            byp       <= 1'b0;
            TDO       <= 1'b0;
            enableTDO <= 1'b0;
        end else begin
            enableTDO <= (state == ST_SH_IR) || (state == ST_SH_DR);
            if (state == ST_CAP_DR && select_BR)
                byp <= 1'b0;
            if (state == ST_SH_IR) begin
                TDO <= ir_shift[0];
            end else if (state == ST_SH_DR) begin
                if (select_BR) begin
                    TDO <= byp;
                    byp <= TDI;
                end else begin
                    TDO <= BSR_scan_out;
                end
            end
        end
    end

    // BSR enables and status outputs, combinational from registered state.
    assign captureDR   = (state == ST_CAP_DR) && bsr_sel;
    assign shiftDR     = (state == ST_SH_DR)  && bsr_sel;
    assign updateDR    = (state == ST_UPD_DR) && bsr_sel;
    assign instruction = ir_active;
    assign tap_state   = state;
    assign reset_bar   = (state != ST_TLR);

endmodule

// File: tb/tb_jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_controller
//   Drives jtag_tap_controller with navigation tables, hand-written corner
//   sequences and random TMS/TDI/reset traffic. A behavioural TAP model
//   (table-based transitions, integer IR/bypass state) predicts every output.
// -----------------------------------------------------------------------------
module tb_jtag_tap_controller;

    localparam int S_TLR = 15, S_RTI = 12, S_SELDR = 7, S_CAPDR = 6, S_SHDR = 2,
                   S_EX1DR = 1, S_PAUDR = 3, S_EX2DR = 0, S_UPDDR = 5,
                   S_SELIR = 4, S_CAPIR = 14, S_SHIR = 10, S_EX1IR = 9,
                   S_PAUIR = 11, S_EX2IR = 8, S_UPDIR = 13;

    logic       TCK = 1'b0;
    logic       reset = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       BSR_scan_out = 1'b0;
    logic       TDO, enableTDO, captureDR, shiftDR, updateDR;
    logic       test_mode, select_BR, reset_bar;
    logic [2:0] instruction;
    logic [3:0] tap_state;

    jtag_tap_controller dut (
        .TCK(TCK), .reset(reset), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .enableTDO(enableTDO), .BSR_scan_out(BSR_scan_out),
        .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
        .test_mode(test_mode), .select_BR(select_BR),
        .instruction(instruction), .tap_state(tap_state), .reset_bar(reset_bar)
    );

    always #5 TCK = ~TCK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         nxt0[16];
    int         nxt1[16];
    int         m_state = S_TLR;
    logic [2:0] m_ir_sh = 3'b001;
    logic [2:0] m_instr = 3'b111;
    logic       m_byp = 1'b0, m_tdo = 1'b0, m_en = 1'b0;

    function automatic bit m_bsr();
        return (m_instr == 3'b000) || (m_instr == 3'b001) || (m_instr == 3'b010);
    endfunction

    task automatic model_edge(input logic tms, input logic tdi, input logic scan, input logic rst);
        int ns;
        bit bypass_sel;
        if (rst) begin
            m_state = S_TLR; m_instr = 3'b111; m_ir_sh = 3'b001;
            m_byp = 0; m_tdo = 0; m_en = 0;
        end else begin
            bypass_sel = !m_bsr();
            ns = tms ? nxt1[m_state] : nxt0[m_state];
            m_en = (m_state == S_SHIR) || (m_state == S_SHDR);
            if (m_state == S_CAPIR) m_ir_sh = 3'b001;
            if (m_state == S_SHIR) begin
                m_tdo   = m_ir_sh[0];
                m_ir_sh = 3'((int'(m_ir_sh) >> 1) + (int'(tdi) * 4));
            end
            if (m_state == S_UPDIR) m_instr = m_ir_sh;
            if (m_state == S_CAPDR && bypass_sel) m_byp = 0;
            if (m_state == S_SHDR) begin
                if (bypass_sel) begin m_tdo = m_byp; m_byp = tdi; end
                else            m_tdo = scan;
            end
            m_state = ns;
            if (ns == S_TLR) m_instr = 3'b111;
        end
    endtask

    task automatic compare_all(input string tag);
        bit bsr;
        bsr = m_bsr();
        check({tag, " outputs"},
              {17'd0, tap_state, instruction, TDO, enableTDO, captureDR, shiftDR,
               updateDR, test_mode, select_BR, reset_bar},
              {17'd0, 4'(m_state), m_instr, m_tdo, m_en,
               1'(bsr && m_state == S_CAPDR), 1'(bsr && m_state == S_SHDR),
               1'(bsr && m_state == S_UPDDR),
               1'(m_instr == 3'b000 || m_instr == 3'b010), 1'(!bsr),
               1'(m_state != S_TLR)});
    endtask

    // One TCK cycle: drive on the falling edge, sample 1 time unit after rise.
    task automatic step(input logic tms, input logic tdi, input logic scan, input logic rst);
        @(negedge TCK);
        TMS = tms; TDI = tdi; BSR_scan_out = scan; reset = rst;
        model_edge(tms, tdi, scan, rst);
        @(posedge TCK);
        #1;
        compare_all("model");
    endtask

    task automatic go_rti();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // From RTI: load an instruction (LSB first) and return to RTI.
    task automatic load_ir(input logic [2:0] code);
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1'(i == 2), code[i], 1'b0, 1'b0);
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        check("load_ir instruction", 32'(instruction), 32'(code));
    endtask

    // From RTI with bypass loaded: shift 1,0,1,1 and expect 0,1,0,1 on TDO.
    task automatic bypass_shift(input string tag);
        logic [3:0] din, dexp;
        din  = 4'b1101;   // applied LSB first: 1,0,1,1
        dexp = 4'b1010;   // expected LSB first: 0,1,0,1
        step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        check({tag, " select_BR"}, 32'(select_BR), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'(i == 3), din[i], 1'b1, 1'b0);
            check({tag, " bypass TDO"}, 32'(TDO), 32'(dexp[i]));
            check({tag, " no BSR enables"}, 32'({captureDR, shiftDR}), 32'd0);
        end
        step(1, 0, 0, 0); step(0, 0, 0, 0);
    endtask

    typedef struct {
        int         len;
        logic [7:0] path;
        logic [3:0] exp_state;
    } nav_t;

    nav_t nav[16];

    initial begin
        int         cap_cnt, sh_cnt, upd_cnt;
        logic [2:0] tdo_seq;
        logic       s;

        // 1149.1 transition table, as the model's knowledge of the FSM.
        nxt0[S_TLR] = S_RTI;     nxt1[S_TLR] = S_TLR;
        nxt0[S_RTI] = S_RTI;     nxt1[S_RTI] = S_SELDR;
        nxt0[S_SELDR] = S_CAPDR; nxt1[S_SELDR] = S_SELIR;
        nxt0[S_SELIR] = S_CAPIR; nxt1[S_SELIR] = S_TLR;
        nxt0[S_CAPDR] = S_SHDR;  nxt1[S_CAPDR] = S_EX1DR;
        nxt0[S_SHDR] = S_SHDR;   nxt1[S_SHDR] = S_EX1DR;
        nxt0[S_EX1DR] = S_PAUDR; nxt1[S_EX1DR] = S_UPDDR;
        nxt0[S_PAUDR] = S_PAUDR; nxt1[S_PAUDR] = S_EX2DR;
        nxt0[S_EX2DR] = S_SHDR;  nxt1[S_EX2DR] = S_UPDDR;
        nxt0[S_UPDDR] = S_RTI;   nxt1[S_UPDDR] = S_SELDR;
        nxt0[S_CAPIR] = S_SHIR;  nxt1[S_CAPIR] = S_EX1IR;
        nxt0[S_SHIR] = S_SHIR;   nxt1[S_SHIR] = S_EX1IR;
        nxt0[S_EX1IR] = S_PAUIR; nxt1[S_EX1IR] = S_UPDIR;
        nxt0[S_PAUIR] = S_PAUIR; nxt1[S_PAUIR] = S_EX2IR;
        nxt0[S_EX2IR] = S_SHIR;  nxt1[S_EX2IR] = S_UPDIR;
        nxt0[S_UPDIR] = S_RTI;   nxt1[S_UPDIR] = S_SELDR;

        // Paths from TLR (TMS bits applied LSB first) to each state.
        nav[0]  = '{0, 8'd0,  4'hF};  nav[1]  = '{1, 8'd0,  4'hC};
        nav[2]  = '{2, 8'd2,  4'h7};  nav[3]  = '{3, 8'd2,  4'h6};
        nav[4]  = '{4, 8'd2,  4'h2};  nav[5]  = '{4, 8'd10, 4'h1};
        nav[6]  = '{5, 8'd10, 4'h3};  nav[7]  = '{6, 8'd42, 4'h0};
        nav[8]  = '{5, 8'd26, 4'h5};  nav[9]  = '{3, 8'd6,  4'h4};
        nav[10] = '{4, 8'd6,  4'hE};  nav[11] = '{5, 8'd6,  4'hA};
        nav[12] = '{5, 8'd22, 4'h9};  nav[13] = '{6, 8'd22, 4'hB};
        nav[14] = '{7, 8'd86, 4'h8};  nav[15] = '{6, 8'd54, 4'hD};

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("reset state", 32'(tap_state), 32'hF);
        check("reset instruction", 32'(instruction), 32'h7);
        check("reset TDO/enableTDO", 32'({TDO, enableTDO}), 32'd0);
        check("reset reset_bar", 32'(reset_bar), 32'd0);

        // 1: five TMS=1 reach TLR from every state.
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            for (int b = 0; b < nav[k].len; b++)
                step(nav[k].path[b], 1'($urandom_range(1)), 1'b0, 1'b0);
            check($sformatf("nav to state %0h", nav[k].exp_state), 32'(tap_state), 32'(nav[k].exp_state));
            for (int b = 0; b < 5; b++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
            check("tms5 state", 32'(tap_state), 32'hF);
            check("tms5 instruction", 32'(instruction), 32'h7);
            check("tms5 reset_bar", 32'(reset_bar), 32'd0);
        end

        // 2: capture 001 then shift in 000 -> EXTEST.
        go_rti();
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'(i == 2), 1'b0, 1'b0, 1'b0);
            tdo_seq[i] = TDO;
            check("IR shift enableTDO", 32'(enableTDO), 32'd1);
        end
        check("IR capture TDO sequence", 32'(tdo_seq), 32'b001);
        step(1, 0, 0, 0);
        check("UpdIR state", 32'(tap_state), 32'hD);
        step(0, 0, 0, 0);
        check("EXTEST instruction", 32'(instruction), 32'd0);
        check("EXTEST test_mode", 32'(test_mode), 32'd1);
        check("EXTEST select_BR", 32'(select_BR), 32'd0);

        // 3: BYPASS path.
        load_ir(3'b111);
        bypass_shift("bypass");

        // 4: SAMPLE_PRELOAD, 268-bit BSR shift.
        load_ir(3'b001);
        check("SAMPLE test_mode", 32'(test_mode), 32'd0);
        cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        cap_cnt += int'(captureDR); sh_cnt += int'(shiftDR); upd_cnt += int'(updateDR);
        step(0, 0, 0, 0);
        cap_cnt += int'(captureDR); sh_cnt += int'(shiftDR); upd_cnt += int'(updateDR);
        for (int i = 0; i < 268; i++) begin
            s = 1'($urandom_range(1));
            step(1'(i == 267), 1'($urandom_range(1)), s, 1'b0);
            if (TDO !== s) check("BSR TDO tracks scan_out", 32'(TDO), 32'(s));
            cap_cnt += int'(captureDR); sh_cnt += int'(shiftDR); upd_cnt += int'(updateDR);
        end
        step(1, 0, 0, 0);
        cap_cnt += int'(captureDR); sh_cnt += int'(shiftDR); upd_cnt += int'(updateDR);
        step(0, 0, 0, 0);
        cap_cnt += int'(captureDR); sh_cnt += int'(shiftDR); upd_cnt += int'(updateDR);
        check("captureDR cycles", 32'(cap_cnt), 32'd1);
        check("shiftDR cycles", 32'(sh_cnt), 32'd268);
        check("updateDR cycles", 32'(upd_cnt), 32'd1);

        // 5: reset mid IR shift aborts load of 010.
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 1'b0, 0, 0);
        step(0, 1'b1, 0, 1);
        check("abort state", 32'(tap_state), 32'hF);
        check("abort instruction", 32'(instruction), 32'h7);
        check("abort enableTDO", 32'(enableTDO), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check("abort never INTEST", 32'(instruction == 3'b010), 32'd0);
        end

        // 6: illegal code decodes as bypass.
        go_rti();
        load_ir(3'b101);
        check("illegal select_BR", 32'(select_BR), 32'd1);
        check("illegal test_mode", 32'(test_mode), 32'd0);
        bypass_shift("illegal");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(3) != 0 ? $urandom_range(1) : 0),
                 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(63) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
